// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encodings, opcode constants and strobe bundle for the instruction sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEMW   = 3'd3,
        ST_IOW    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [2:0] OP_ALU   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_IN    = 3'd3;
    localparam logic [2:0] OP_OUT   = 3'd4;
    localparam logic [2:0] OP_JMP   = 3'd5;
    localparam logic [2:0] OP_JC    = 3'd6;
    localparam logic [2:0] OP_BNE   = 3'd7;

    typedef struct packed {
        logic ir_load;
        logic pc_inc;
        logic pc_load;
        logic j;
        logic jc;
        logic ina;
        logic rm;
        logic wm;
        logic sin;
        logic sout;
        logic wr;
        logic neq;
    } strobe_t;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/seq_strobe_dec.sv
// rtl/seq_strobe_dec.sv - combinational strobe decode from registered state, latched opcode and live handshakes
module seq_strobe_dec
    import seq_pkg::*;
(
    input  state_t      state_i,
    input  logic [2:0]  op_i,
    input  logic        flag_c_i,
    input  logic        flag_z_i,
    input  logic        ack_i,
    input  logic        in_valid_i,
    input  logic        out_ready_i,
    output strobe_t     strb_o
);

    always_comb begin
        strb_o = '0;
        case (state_i)
            ST_FETCH: begin
                strb_o.ir_load = ack_i;
                strb_o.pc_inc  = ack_i;
            end
            ST_EXEC: begin
                case (op_i)
                    OP_ALU: begin
                        strb_o.ina = 1'b1;
                        strb_o.wr  = 1'b1;
                    end
                    OP_JMP: begin
                        strb_o.j       = 1'b1;
                        strb_o.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        strb_o.jc      = 1'b1;
                        strb_o.pc_load = flag_c_i;
                    end
                    OP_BNE: begin
                        strb_o.neq     = 1'b1;
                        strb_o.pc_load = ~flag_z_i;
                    end
                    default: ;
                endcase
            end
            ST_MEMW: begin
                strb_o.rm = ack_i && (op_i == OP_LOAD);
                strb_o.wm = ack_i && (op_i == OP_STORE);
            end
            ST_IOW: begin
                strb_o.sin  = in_valid_i && (op_i == OP_IN);
                strb_o.sout = out_ready_i && (op_i == OP_OUT);
            end
            ST_WB: strb_o.wr = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer FSM; SEQ_TIMEOUT_EN adds the wait timeout and seq_err
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    input  logic        mem_ack,
    input  logic        io_in_valid,
    input  logic        io_out_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        J,
    output logic        JC,
    output logic        INA,
    output logic        RM,
    output logic        WM,
    output logic        SIN,
    output logic        SOUT,
    output logic        WR,
    output logic        NEQ,
    output logic        seq_err,
    output logic [2:0]  state_o
);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        ack;
    logic        timeout;
    strobe_t     strb;

    // An ack only counts while a request is actually outstanding.
    assign ack = mem_ack && mem_req_q;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       seq_err_q;
    logic       waiting;

    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEMW) || (state_q == ST_IOW);
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            op_q      <= OP_ALU;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q     <= '0;
            seq_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
`ifdef SEQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
            seq_err_q <= seq_err_q | timeout;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        timeout = 1'b0;
        case (state_q)
            ST_FETCH:  if (ack) state_d = ST_DECODE;
            ST_DECODE: begin
                op_d    = opcode;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem_op(op_q))
                    state_d = ST_MEMW;
                else if ((op_q == OP_IN) || (op_q == OP_OUT))
                    state_d = ST_IOW;
                else
                    state_d = ST_FETCH;
            end
            ST_MEMW:   if (ack) state_d = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
            ST_IOW: begin
                if ((op_q == OP_IN) && io_in_valid)
                    state_d = ST_WB;
                else if ((op_q == OP_OUT) && io_out_ready)
                    state_d = ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
`ifdef SEQ_TIMEOUT_EN
        // A wait state that has not progressed by its last allowed cycle is abandoned.
        timeout = waiting && (state_d == state_q) && (cnt_q == TO_LAST);
        if (timeout)
            state_d = ST_FETCH;
        cnt_d = (!waiting || timeout || (state_d != state_q)) ? 8'd0 : cnt_q + 8'd1;
`endif
        mem_req_d = ((state_d == ST_FETCH) || (state_d == ST_MEMW)) && !timeout;
        mem_we_d  = (state_d == ST_MEMW) && (op_q == OP_STORE) && !timeout;
    end

    seq_strobe_dec u_dec (
        .state_i     (state_q),
        .op_i        (op_q),
        .flag_c_i    (flag_c),
        .flag_z_i    (flag_z),
        .ack_i       (ack),
        .in_valid_i  (io_in_valid),
        .out_ready_i (io_out_ready),
        .strb_o      (strb)
    );

    always_comb begin
        mem_req = mem_req_q;
        mem_we  = mem_we_q;
        ir_load = strb.ir_load;
        pc_inc  = strb.pc_inc;
        pc_load = strb.pc_load;
        J       = strb.j;
        JC      = strb.jc;
        INA     = strb.ina;
        RM      = strb.rm;
        WM      = strb.wm;
        SIN     = strb.sin;
        SOUT    = strb.sout;
        WR      = strb.wr;
        NEQ     = strb.neq;
        state_o = state_q;
`ifdef SEQ_TIMEOUT_EN
        seq_err = seq_err_q;
`else
        seq_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed vector bench for instr_sequencer
module tb_instr_sequencer;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    localparam logic [11:0] S_IR = 12'h800, S_PCI = 12'h400, S_PCL = 12'h200, S_J = 12'h100;
    localparam logic [11:0] S_JC = 12'h080, S_INA = 12'h040, S_RM = 12'h020, S_WM = 12'h010;
    localparam logic [11:0] S_SIN = 12'h008, S_SOUT = 12'h004, S_WR = 12'h002, S_NEQ = 12'h001;
    localparam logic [11:0] S_F = S_IR | S_PCI;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       flag_c = 1'b0, flag_z = 1'b0, mem_ack = 1'b0;
    logic       io_in_valid = 1'b0, io_out_ready = 1'b0;
    logic       mem_req, mem_we, ir_load, pc_inc, pc_load;
    logic       J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ, seq_err;
    logic [2:0] state_o;
    logic [11:0] strb;

    assign strb = {ir_load, pc_inc, pc_load, J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ};

    instr_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .mem_ack(mem_ack), .io_in_valid(io_in_valid), .io_out_ready(io_out_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .J(J), .JC(JC), .INA(INA), .RM(RM), .WM(WM), .SIN(SIN), .SOUT(SOUT), .WR(WR), .NEQ(NEQ),
        .seq_err(seq_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        fc;
        logic        fz;
        int          fd;
        int          dd;
        int          iod;
        int          exp_cyc;
        int          exp_wait;
        logic [11:0] exp_strb;
    } vec_t;

    // Drives one instruction from FETCH (request already up) back to the next FETCH.
    task automatic run_instr(input vec_t v, output int cyc, output int waitc,
                             output logic [11:0] seen, output logic bad);
        int cnt[12];
        int req_run;
        int io_run;
        logic [2:0] prev;
        cyc = 0; waitc = 0; seen = '0; bad = 1'b0;
        req_run = 0; io_run = 0; prev = 3'd7;
        foreach (cnt[i]) cnt[i] = 0;
        opcode = v.op; flag_c = v.fc; flag_z = v.fz;
        for (int k = 0; k < 200; k++) begin
            if (k > 0 && state_o == 3'd0 && prev != 3'd0) break;
            if (!mem_req) req_run = 0;
            else if (state_o == prev) req_run++;
            else req_run = 1;
            mem_ack = mem_req && (req_run == ((state_o == 3'd0) ? v.fd : v.dd) + 1);
            if (state_o == 3'd4) io_run++; else io_run = 0;
            io_in_valid  = (io_run > v.iod);
            io_out_ready = (io_run > v.iod);
            #1;
            for (int b = 0; b < 12; b++) if (strb[b]) cnt[b]++;
            if (state_o == 3'd3 || state_o == 3'd4) waitc++;
            if (state_o == 3'd3 && !mem_req) bad = 1'b1;
            cyc++;
            prev = state_o;
            @(negedge clk);
        end
        for (int b = 0; b < 12; b++) begin
            seen[b] = (cnt[b] == 1);
            if (cnt[b] > 1) bad = 1'b1;
        end
        mem_ack = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
    endtask

    vec_t vecs[13];

    initial begin
        int cyc, waitc;
        logic [11:0] seen;
        logic bad;

        //      op  fc    fz    fd dd iod cyc wait strobes
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 0, 0, 0, 3, 0, S_F | S_INA | S_WR};
        vecs[1]  = '{3'd0, 1'b0, 1'b0, 2, 0, 0, 5, 0, S_F | S_INA | S_WR};
        vecs[2]  = '{3'd1, 1'b0, 1'b0, 0, 3, 0, 8, 4, S_F | S_RM | S_WR};
        vecs[3]  = '{3'd2, 1'b0, 1'b0, 0, 0, 0, 4, 1, S_F | S_WM};
        vecs[4]  = '{3'd2, 1'b0, 1'b0, 1, 2, 0, 7, 3, S_F | S_WM};
        vecs[5]  = '{3'd3, 1'b0, 1'b0, 0, 0, 0, 5, 1, S_F | S_SIN | S_WR};
        vecs[6]  = '{3'd3, 1'b0, 1'b0, 0, 0, 2, 7, 3, S_F | S_SIN | S_WR};
        vecs[7]  = '{3'd4, 1'b0, 1'b0, 0, 0, 2, 6, 3, S_F | S_SOUT};
        vecs[8]  = '{3'd5, 1'b0, 1'b0, 0, 0, 0, 3, 0, S_F | S_J | S_PCL};
        vecs[9]  = '{3'd6, 1'b0, 1'b0, 0, 0, 0, 3, 0, S_F | S_JC};
        vecs[10] = '{3'd6, 1'b1, 1'b0, 0, 0, 0, 3, 0, S_F | S_JC | S_PCL};
        vecs[11] = '{3'd7, 1'b0, 1'b1, 0, 0, 0, 3, 0, S_F | S_NEQ};
        vecs[12] = '{3'd7, 1'b0, 1'b0, 0, 0, 0, 3, 0, S_F | S_NEQ | S_PCL};

        // Reset state, with a stray ack that must be ignored.
        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_req", 32'({mem_req, mem_we}), 32'd0);
        check("rst_strb", 32'(strb), 32'd0);
        check("rst_err", 32'(seq_err), 32'd0);

        // First ALU instruction: ack ignored in first FETCH cycle, honoured in the second.
        reset_n = 1'b1;
        opcode = 3'd0;
        #1;
        check("fetch1_req", 32'(mem_req), 32'd0);
        check("fetch1_ign_ack", 32'(strb), 32'd0);
        @(negedge clk); #1;
        check("fetch2_state", 32'(state_o), 32'd0);
        check("fetch2_req", 32'(mem_req), 32'd1);
        check("fetch2_strb", 32'(strb), 32'(S_F));
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("decode_state", 32'(state_o), 32'd1);
        check("decode_req", 32'(mem_req), 32'd0);
        @(negedge clk); #1;
        check("exec_state", 32'(state_o), 32'd2);
        check("exec_strb", 32'(strb), 32'(S_INA | S_WR));
        @(negedge clk); #1;
        check("back_fetch", 32'({state_o, mem_req}), 32'({3'd0, 1'b1}));
        check("back_strb", 32'(strb), 32'd0);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i], cyc, waitc, seen, bad);
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_wait", i), 32'(waitc), 32'(vecs[i].exp_wait));
            check($sformatf("v%0d_strobes", i), 32'({bad, seen}), 32'({1'b0, vecs[i].exp_strb}));
        end

        // STORE aborted by reset while waiting in MEMW.
        opcode = 3'd2;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("memw_entry", 32'({state_o, mem_req, mem_we}), 32'({3'd3, 1'b1, 1'b1}));
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_req", 32'({mem_req, mem_we}), 32'd0);
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_strb", 32'(strb), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef SEQ_TIMEOUT_EN
        begin
            int memw;
            logic wm_seen;
            memw = 0; wm_seen = 1'b0;
            @(negedge clk);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            repeat (2) @(negedge clk);
            for (int k = 0; k < 40; k++) begin
                #1;
                if (state_o != 3'd3) break;
                memw++;
                if (WM) wm_seen = 1'b1;
                @(negedge clk);
            end
            check("to_memw_cycles", 32'(memw), 32'(TO));
            check("to_err", 32'(seq_err), 32'd1);
            check("to_state_req", 32'({state_o, mem_req}), 32'({3'd0, 1'b0}));
            check("to_no_wm", 32'(wm_seen), 32'd0);
            @(negedge clk); #1;
            check("to_sticky", 32'({seq_err, mem_req}), 32'({1'b1, 1'b1}));
        end
`else
        repeat (3) @(negedge clk);
        #1;
        check("err_tied", 32'(seq_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
